// File: rtl/phase_sequencer.sv
// phase_sequencer: four-phase (FETCH/DECODE/EXECUTE/WRITEBACK) instruction sequencer
//   with start/HALT control and retired-instruction and running-cycle counters.
// Ports:
//   clock_i          system clock, rising edge
//   control_reset_i  asynchronous active-low reset
//   start_i          start request, honoured only while stopped
//   instr_i          instruction word, opcode in [15:12]
//   mem_ready_i      completes the current fetch or LOAD/STORE access
//   LT_flag_i        ALU less-than flag, used by BLT in EXECUTE
//   state_o          current phase: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 WRITEBACK
//   opcode_o         opcode latched at fetch completion
//   mem_req_o        memory access request
//   PC_EN_o          PC increment strobe, high in the cycle a fetch completes
//   pc_load_o        branch-target load strobe for a taken BLT
//   running_o        high while executing instructions
//   instr_count_o    retired instruction count (wraps)
//   cycle_count_o    running cycle count (wraps)
module phase_sequencer (
  input  logic        clock_i,
  input  logic        control_reset_i,
  input  logic        start_i,
  input  logic [15:0] instr_i,
  input  logic        mem_ready_i,
  input  logic        LT_flag_i,
  output logic [1:0]  state_o,
  output logic [3:0]  opcode_o,
  output logic        mem_req_o,
  output logic        PC_EN_o,
  output logic        pc_load_o,
  output logic        running_o,
  output logic [15:0] instr_count_o,
  output logic [15:0] cycle_count_o
);
  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } phase_e;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_BLT   = 4'h6;
  phase_e      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic        running_q, running_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic [15:0] cycle_count_q, cycle_count_d;
  logic        is_mem;
  logic        unused_instr_bits;
  assign unused_instr_bits = ^instr_i[11:0];
  assign is_mem = (opcode_q == OP_LOAD) || (opcode_q == OP_STORE);
  always_ff @(posedge clock_i or negedge control_reset_i) begin
    if (!control_reset_i) begin
      state_q       <= FETCH;
      opcode_q      <= 4'h0;
      running_q     <= 1'b0;
      instr_count_q <= 16'h0000;
      cycle_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      running_q     <= running_d;
      instr_count_q <= instr_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end
  // Start is only looked at while stopped, so a start coinciding with a HALT
  // decode is dropped and a fresh start is needed afterwards.
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    running_d     = running_q;
    instr_count_d = instr_count_q;
    cycle_count_d = cycle_count_q + {15'd0, running_q};
    if (!running_q) begin
      state_d   = FETCH;
      running_d = start_i;
    end else begin
      case (state_q)
        FETCH: begin
          if (mem_ready_i) begin
            opcode_d = instr_i[15:12];
            state_d  = DECODE;
          end
        end
        DECODE: begin
          running_d = (opcode_q != OP_HALT);
          state_d   = (opcode_q == OP_HALT) ? FETCH : EXECUTE;
        end
        EXECUTE: state_d = (!is_mem || mem_ready_i) ? WRITEBACK : EXECUTE;
        WRITEBACK: begin
          instr_count_d = instr_count_q + 16'd1;
          state_d       = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end
  assign state_o       = state_q;
  assign opcode_o      = opcode_q;
  assign running_o     = running_q;
  assign instr_count_o = instr_count_q;
  assign cycle_count_o = cycle_count_q;
  assign mem_req_o     = running_q && ((state_q == FETCH) || ((state_q == EXECUTE) && is_mem));
  assign PC_EN_o       = running_q && (state_q == FETCH) && mem_ready_i;
  assign pc_load_o     = running_q && (state_q == EXECUTE) && (opcode_q == OP_BLT) && LT_flag_i;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed self-checking bench for phase_sequencer.
module tb_phase_sequencer;
  logic        clock_i = 1'b0;
  logic        control_reset_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] instr_i = 16'h0000;
  logic        mem_ready_i = 1'b0;
  logic        LT_flag_i = 1'b0;
  logic [1:0]  state_o;
  logic [3:0]  opcode_o;
  logic        mem_req_o;
  logic        PC_EN_o;
  logic        pc_load_o;
  logic        running_o;
  logic [15:0] instr_count_o;
  logic [15:0] cycle_count_o;
  int errors = 0;
  int checks = 0;

  phase_sequencer dut (
    .clock_i(clock_i),
    .control_reset_i(control_reset_i),
    .start_i(start_i),
    .instr_i(instr_i),
    .mem_ready_i(mem_ready_i),
    .LT_flag_i(LT_flag_i),
    .state_o(state_o),
    .opcode_o(opcode_o),
    .mem_req_o(mem_req_o),
    .PC_EN_o(PC_EN_o),
    .pc_load_o(pc_load_o),
    .running_o(running_o),
    .instr_count_o(instr_count_o),
    .cycle_count_o(cycle_count_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({state_o, opcode_o, running_o, mem_req_o, PC_EN_o, pc_load_o} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got st=%0d op=%h run=%b req=%b pcen=%b pcl=%b, want all 0",
               state_o, opcode_o, running_o, mem_req_o, PC_EN_o, pc_load_o);
    end
    checks++;
    if (instr_count_o !== 16'h0 || cycle_count_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_counts: got ic=%h cc=%h, want 0 0", instr_count_o, cycle_count_o);
    end
    control_reset_i = 1'b1;
    mem_ready_i = 1'b1;
    instr_i = 16'h1000;
    repeat (2) tick();
    checks++;
    if (running_o !== 1'b0 || PC_EN_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got run=%b pcen=%b req=%b, want 0 0 0", running_o, PC_EN_o, mem_req_o);
    end
  endtask

  task automatic test_basic();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (running_o !== 1'b1 || state_o !== 2'd0 || PC_EN_o !== 1'b1 || mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_fetch: got run=%b st=%0d pcen=%b req=%b, want 1 0 1 1", running_o, state_o, PC_EN_o, mem_req_o);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (state_o !== i[1:0] || PC_EN_o !== 1'b0) begin
        errors++;
        $display("FAIL basic_phase%0d: got st=%0d pcen=%b, want %0d 0", i, state_o, PC_EN_o, i);
      end
    end
    mem_ready_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 2'd0 || opcode_o !== 4'h1 || instr_count_o !== 16'd1 || cycle_count_o !== 16'd4) begin
      errors++;
      $display("FAIL basic_retire: got st=%0d op=%h ic=%0d cc=%0d, want 0 1 1 4", state_o, opcode_o, instr_count_o, cycle_count_o);
    end
  endtask

  task automatic test_fetch_wait();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state_o !== 2'd0 || mem_req_o !== 1'b1 || PC_EN_o !== 1'b0) begin
        errors++;
        $display("FAIL fetch_wait%0d: got st=%0d req=%b pcen=%b, want 0 1 0", i, state_o, mem_req_o, PC_EN_o);
      end
      tick();
    end
    mem_ready_i = 1'b1;
    #1;
    checks++;
    if (state_o !== 2'd0 || mem_req_o !== 1'b1 || PC_EN_o !== 1'b1) begin
      errors++;
      $display("FAIL fetch_done: got st=%0d req=%b pcen=%b, want 0 1 1", state_o, mem_req_o, PC_EN_o);
    end
    repeat (4) tick();
    checks++;
    if (instr_count_o !== 16'd2 || cycle_count_o !== 16'd11) begin
      errors++;
      $display("FAIL fetch_wait_retire: got ic=%0d cc=%0d, want 2 11", instr_count_o, cycle_count_o);
    end
  endtask

  task automatic test_branch();
    instr_i = 16'h6000;
    LT_flag_i = 1'b1;
    tick();
    checks++;
    if (pc_load_o !== 1'b0) begin
      errors++;
      $display("FAIL blt_decode: got pcl=%b, want 0", pc_load_o);
    end
    tick();
    checks++;
    if (state_o !== 2'd2 || pc_load_o !== 1'b1) begin
      errors++;
      $display("FAIL blt_taken: got st=%0d pcl=%b, want 2 1", state_o, pc_load_o);
    end
    tick();
    checks++;
    if (state_o !== 2'd3 || pc_load_o !== 1'b0) begin
      errors++;
      $display("FAIL blt_wb: got st=%0d pcl=%b, want 3 0", state_o, pc_load_o);
    end
    tick();
    checks++;
    if (state_o !== 2'd0 || pc_load_o !== 1'b0) begin
      errors++;
      $display("FAIL blt_fetch: got st=%0d pcl=%b, want 0 0", state_o, pc_load_o);
    end
    LT_flag_i = 1'b0;
    repeat (2) tick();
    checks++;
    if (state_o !== 2'd2 || opcode_o !== 4'h6 || pc_load_o !== 1'b0) begin
      errors++;
      $display("FAIL blt_not_taken: got st=%0d op=%h pcl=%b, want 2 6 0", state_o, opcode_o, pc_load_o);
    end
    repeat (2) tick();
    checks++;
    if (instr_count_o !== 16'd4 || cycle_count_o !== 16'd19) begin
      errors++;
      $display("FAIL blt_retire: got ic=%0d cc=%0d, want 4 19", instr_count_o, cycle_count_o);
    end
  endtask

  task automatic test_load_wait();
    instr_i = 16'h4000;
    tick();
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin
        mem_ready_i = 1'b1;
        #1;
      end
      checks++;
      if (state_o !== 2'd2 || mem_req_o !== 1'b1 || PC_EN_o !== 1'b0) begin
        errors++;
        $display("FAIL load_exec%0d: got st=%0d req=%b pcen=%b, want 2 1 0", i, state_o, mem_req_o, PC_EN_o);
      end
    end
    tick();
    checks++;
    if (state_o !== 2'd3 || mem_req_o !== 1'b0 || instr_count_o !== 16'd4) begin
      errors++;
      $display("FAIL load_wb: got st=%0d req=%b ic=%0d, want 3 0 4", state_o, mem_req_o, instr_count_o);
    end
    tick();
    checks++;
    if (state_o !== 2'd0 || instr_count_o !== 16'd5 || cycle_count_o !== 16'd25) begin
      errors++;
      $display("FAIL load_retire: got st=%0d ic=%0d cc=%0d, want 0 5 25", state_o, instr_count_o, cycle_count_o);
    end
  endtask

  task automatic test_halt();
    instr_i = 16'hF000;
    tick();
    checks++;
    if (state_o !== 2'd1 || running_o !== 1'b1 || opcode_o !== 4'hF) begin
      errors++;
      $display("FAIL halt_decode: got st=%0d run=%b op=%h, want 1 1 f", state_o, running_o, opcode_o);
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (running_o !== 1'b0 || state_o !== 2'd0 || instr_count_o !== 16'd5 || cycle_count_o !== 16'd27) begin
      errors++;
      $display("FAIL halt_stop: got run=%b st=%0d ic=%0d cc=%0d, want 0 0 5 27", running_o, state_o, instr_count_o, cycle_count_o);
    end
    checks++;
    if (mem_req_o !== 1'b0 || PC_EN_o !== 1'b0) begin
      errors++;
      $display("FAIL halt_outputs: got req=%b pcen=%b, want 0 0", mem_req_o, PC_EN_o);
    end
    tick();
    checks++;
    if (running_o !== 1'b0 || cycle_count_o !== 16'd27) begin
      errors++;
      $display("FAIL halt_start_dropped: got run=%b cc=%0d, want 0 27", running_o, cycle_count_o);
    end
    instr_i = 16'h1000;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    checks++;
    if (running_o !== 1'b1 || state_o !== 2'd1 || opcode_o !== 4'h1 || cycle_count_o !== 16'd28) begin
      errors++;
      $display("FAIL halt_resume: got run=%b st=%0d op=%h cc=%0d, want 1 1 1 28", running_o, state_o, opcode_o, cycle_count_o);
    end
    repeat (3) tick();
    checks++;
    if (instr_count_o !== 16'd6 || cycle_count_o !== 16'd31) begin
      errors++;
      $display("FAIL halt_resume_retire: got ic=%0d cc=%0d, want 6 31", instr_count_o, cycle_count_o);
    end
  endtask

  task automatic test_reset_mid_exec();
    instr_i = 16'h4000;
    mem_ready_i = 1'b1;
    tick();
    mem_ready_i = 1'b0;
    tick();
    checks++;
    if (state_o !== 2'd2 || mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: got st=%0d req=%b, want 2 1", state_o, mem_req_o);
    end
    #2 control_reset_i = 1'b0;
    #1;
    checks++;
    if ({state_o, opcode_o, running_o, mem_req_o, PC_EN_o, pc_load_o} !== 10'b0 ||
        instr_count_o !== 16'h0 || cycle_count_o !== 16'h0) begin
      errors++;
      $display("FAIL async_abort: got st=%0d op=%h run=%b req=%b pcen=%b pcl=%b ic=%h cc=%h, want all 0",
               state_o, opcode_o, running_o, mem_req_o, PC_EN_o, pc_load_o, instr_count_o, cycle_count_o);
    end
    tick();
    control_reset_i = 1'b1;
    mem_ready_i = 1'b1;
    repeat (3) tick();
    checks++;
    if (running_o !== 1'b0 || state_o !== 2'd0 || instr_count_o !== 16'h0 || cycle_count_o !== 16'h0) begin
      errors++;
      $display("FAIL post_abort_idle: got run=%b st=%0d ic=%0d cc=%0d, want 0 0 0 0", running_o, state_o, instr_count_o, cycle_count_o);
    end
  endtask

  task automatic test_wrap();
    instr_i = 16'h1000;
    mem_ready_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (16384 * 4) tick();
    checks++;
    if (cycle_count_o !== 16'h0000 || instr_count_o !== 16'h4000 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL cycle_wrap: got cc=%h ic=%h st=%0d, want 0000 4000 0", cycle_count_o, instr_count_o, state_o);
    end
    repeat (4) tick();
    checks++;
    if (cycle_count_o !== 16'h0004 || instr_count_o !== 16'h4001) begin
      errors++;
      $display("FAIL after_wrap: got cc=%h ic=%h, want 0004 4001", cycle_count_o, instr_count_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fetch_wait();
    test_branch();
    test_load_wait();
    test_halt();
    test_reset_mid_exec();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 clock  input  1  system clock; all state updates on rising edge.
REQ-002 control_reset  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  start request, sampled on rising clock edge while stopped.
REQ-004 instr  input  16  instruction word from memory; opcode = instr[15:12].
REQ-005 mem_ready  input  1  memory handshake; completes the current memory access.
REQ-006 LT_flag  input  1  ALU less-than flag, sampled in EXECUTE.
REQ-007 state  output  2  phase to the control matrix: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 WRITEBACK.
REQ-008 opcode  output  4  registered opcode of the instruction in flight.
REQ-009 mem_req  output  1  memory access request.
REQ-010 PC_EN  output  1  one-cycle program-counter increment strobe.
REQ-011 pc_load  output  1  one-cycle branch-target load strobe.
REQ-012 running  output  1  high while the sequencer executes instructions.
REQ-013 instr_count  output  16  count of retired instructions.
REQ-014 cycle_count  output  16  count of clock cycles spent running.

Function
REQ-015 Opcode decode SHALL be: 4'b1111 HALT; 4'b0100 LOAD; 4'b0101 STORE; 4'b0110 BLT; all others are single-cycle EXECUTE.
REQ-016 While stopped, state SHALL hold 0, and mem_req, PC_EN and pc_load SHALL be 0.
REQ-017 start=1 while stopped SHALL set running=1 on that edge, with state=0; start while running SHALL be ignored.
REQ-018 FETCH: mem_req SHALL be 1; the state SHALL hold until mem_ready=1; on that edge opcode SHALL load instr[15:12] and state SHALL go to 1.
REQ-019 PC_EN SHALL be combinational: running AND state==0 AND mem_ready, so it is high exactly in the cycle a fetch completes.
REQ-020 DECODE SHALL take one cycle. If opcode==HALT, running SHALL clear and state SHALL go to 0 without retiring the instruction. Otherwise state SHALL go to 2.
REQ-021 EXECUTE for LOAD/STORE: mem_req SHALL be 1 and the state SHALL hold until mem_ready=1, then go to 3.
REQ-022 EXECUTE for any other opcode SHALL take one cycle and then go to 3.
REQ-023 pc_load SHALL be combinational: state==2 AND opcode==BLT AND LT_flag; it SHALL be high exactly one cycle per taken branch.
REQ-024 mem_ready SHALL be ignored outside FETCH and LOAD/STORE EXECUTE.
REQ-025 WRITEBACK SHALL take one cycle, increment instr_count, and go to 0.
REQ-026 cycle_count SHALL increment on every edge where running=1, including the edge that clears running at HALT.
REQ-027 Both counters SHALL wrap from 16'hFFFF to 16'h0000 with no flag; they SHALL NOT clear on start.
REQ-028 Minimum instruction latency SHALL be 4 cycles: FETCH with mem_ready already high, then DECODE, EXECUTE, WRITEBACK.
REQ-029 start and a HALT decode in the same cycle: HALT SHALL win, and a new start is required.

Reset
REQ-030 control_reset=0 SHALL immediately force state=0, opcode=4'b0000, running=0, instr_count=0 and cycle_count=0, regardless of the clock.
REQ-031 With running=0, the outputs mem_req, PC_EN and pc_load SHALL read 0 during reset.
REQ-032 Reset asserted mid-instruction SHALL abort that instruction; it SHALL NOT be retired or counted.
REQ-033 After reset release, the block SHALL remain stopped until start is sampled high.

Verification
REQ-034 Reset, pulse start, mem_ready=1, instr=16'h1000 -> state 0,1,2,3,0; PC_EN high only in cycle 1; instr_count=1 after 4 cycles.
REQ-035 Fetch with mem_ready held low 3 cycles, then high -> state stays 0 for 4 cycles; PC_EN high only on the 4th cycle; mem_req high throughout.
REQ-036 BLT (16'h6000) with LT_flag=1, then BLT with LT_flag=0 -> pc_load pulses one cycle in the first EXECUTE only.
REQ-037 LOAD (16'h4000) with mem_ready low 2 cycles in EXECUTE -> state 2 held 3 cycles with mem_req=1; instruction retires afterwards.
REQ-038 HALT (16'hF000) -> running clears after DECODE; state=0; instr_count unchanged; start then resumes fetching.
REQ-039 Preload near wrap by running 65535 NOPs, then one more -> instr_count=16'h0000. Separately, assert reset during EXECUTE -> all outputs take reset values immediately.
